// File: rtl/cxl_mem_responder.sv
// AXI-MM 512-bit memory responder with independent write and read engines.
// Optional CXL_MEM_RANGE_CHECK_EN: out-of-window beats are dropped/zeroed and answered with 2'b11.
module cxl_mem_responder #(
    parameter int          MEM_DEPTH_LOG2 = 8,
    parameter logic [63:0] BASE_ADDR      = 64'h0,
    parameter int          RD_LATENCY     = 2
) (
    input  logic         axi4_mm_clk,
    input  logic         axi4_mm_rst,
    input  logic [11:0]  awid,
    input  logic [63:0]  awaddr,
    input  logic [9:0]   awlen,
    input  logic [2:0]   awsize,
    input  logic         awvalid,
    output logic         awready,
    input  logic [511:0] wdata,
    input  logic [63:0]  wstrb,
    input  logic         wlast,
    input  logic         wvalid,
    output logic         wready,
    output logic [11:0]  bid,
    output logic [1:0]   bresp,
    output logic         bvalid,
    input  logic         bready,
    input  logic [11:0]  arid,
    input  logic [63:0]  araddr,
    input  logic [9:0]   arlen,
    input  logic [2:0]   arsize,
    input  logic         arvalid,
    output logic         arready,
    output logic [11:0]  rid,
    output logic [511:0] rdata,
    output logic [1:0]   rresp,
    output logic         rlast,
    output logic         rvalid,
    input  logic         rready
);
    // state  | meaning
    // W_IDLE | awready high, waiting for a write address
    // W_DATA | accepting write beats into the array
    // W_RESP | bvalid high until bready
    // R_IDLE | arready high, waiting for a read address
    // R_WAIT | latency down-counter running
    // R_DATA | rvalid high, one registered beat per rready
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

    localparam int         D        = MEM_DEPTH_LOG2;
    localparam logic [3:0] LAT_LOAD = 4'(RD_LATENCY > 1 ? RD_LATENCY - 2 : 0);

    logic [511:0] mem_q [2**D];

    w_state_e     w_state_q;
    logic         awready_q, wready_q, bvalid_q, woor_q;
    logic [11:0]  bid_q;
    logic [1:0]   bresp_q;
    logic [57:0]  waddr_q;
    logic [9:0]   awlen_q, wcnt_q;

    r_state_e     r_state_q;
    logic         arready_q, rvalid_q, rlast_q;
    logic [11:0]  rid_q;
    logic [1:0]   rresp_q;
    logic [511:0] rdata_q;
    logic [57:0]  raddr_q, r_rd_line;
    logic [9:0]   arlen_q, rcnt_q;
    logic [3:0]   lat_q;

    logic [63:0]  w_off, r_off;
    logic [D-1:0] w_idx, r_idx;
    logic         w_oor, r_oor;
    logic         w_last_by_len, w_end, w_beat;

    // Read line: next burst address comes straight from araddr in R_IDLE, the
    // current beat in R_WAIT, and the following beat while in R_DATA.
    always_comb begin
        r_rd_line = raddr_q;
        case (r_state_q)
            R_IDLE:  r_rd_line = araddr[63:6];
            R_DATA:  r_rd_line = raddr_q + 58'd1;
            default: r_rd_line = raddr_q;
        endcase
    end

    assign w_off = {waddr_q, 6'b0} - BASE_ADDR;
    assign r_off = {r_rd_line, 6'b0} - BASE_ADDR;
    assign w_idx = w_off[D+5:6];
    assign r_idx = r_off[D+5:6];

`ifdef CXL_MEM_RANGE_CHECK_EN
    // Below BASE_ADDR the offset wraps to a huge value, so one upper-bit test covers both ends.
    assign w_oor = |w_off[63:D+6];
    assign r_oor = |r_off[63:D+6];
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{awsize, arsize, awaddr[5:0], araddr[5:0],
                           w_off[63:D+6], w_off[5:0], r_off[63:D+6], r_off[5:0]};

    assign w_last_by_len = (wcnt_q == awlen_q);
    assign w_end         = wlast || w_last_by_len;
    assign w_beat        = (w_state_q == W_DATA) && wvalid && wready_q;

    always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
        if (axi4_mm_rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            waddr_q   <= '0;
            awlen_q   <= '0;
            wcnt_q    <= '0;
            woor_q    <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (awvalid && awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        bid_q     <= awid;
                        waddr_q   <= awaddr[63:6];
                        awlen_q   <= awlen;
                        wcnt_q    <= '0;
                        woor_q    <= 1'b0;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        waddr_q <= waddr_q + 58'd1;
                        wcnt_q  <= wcnt_q + 10'd1;
                        woor_q  <= woor_q | w_oor;
                        if (w_end) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= (woor_q || w_oor) ? 2'b11 :
                                         ((wlast != w_last_by_len) ? 2'b10 : 2'b00);
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi4_mm_clk) begin
        if (w_beat && !w_oor) begin
            for (int b = 0; b < 64; b++) begin
                if (wstrb[b]) mem_q[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
        if (axi4_mm_rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            raddr_q   <= '0;
            arlen_q   <= '0;
            rcnt_q    <= '0;
            lat_q     <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        rid_q     <= arid;
                        raddr_q   <= araddr[63:6];
                        arlen_q   <= arlen;
                        rcnt_q    <= '0;
                        lat_q     <= LAT_LOAD;
                        if (RD_LATENCY == 1) begin
                            rvalid_q  <= 1'b1;
                            rdata_q   <= r_oor ? '0 : mem_q[r_idx];
                            rresp_q   <= r_oor ? 2'b11 : 2'b00;
                            rlast_q   <= (arlen == 10'd0);
                            r_state_q <= R_DATA;
                        end else begin
                            r_state_q <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (lat_q == 4'd0) begin
                        rvalid_q  <= 1'b1;
                        rdata_q   <= r_oor ? '0 : mem_q[r_idx];
                        rresp_q   <= r_oor ? 2'b11 : 2'b00;
                        rlast_q   <= (arlen_q == 10'd0);
                        r_state_q <= R_DATA;
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            raddr_q <= raddr_q + 58'd1;
                            rcnt_q  <= rcnt_q + 10'd1;
                            rlast_q <= ((rcnt_q + 10'd1) == arlen_q);
                            rdata_q <= r_oor ? '0 : mem_q[r_idx];
                            rresp_q <= r_oor ? 2'b11 : 2'b00;
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_cxl_mem_responder.sv
// Directed bench for cxl_mem_responder; inputs driven and outputs sampled on the falling edge.
module tb_cxl_mem_responder;
    localparam int          DEPTH_LOG2 = 8;
    localparam logic [63:0] BASE       = 64'h0001_0000;
    localparam int          RDL        = 2;

    logic         axi4_mm_clk = 1'b0;
    logic         axi4_mm_rst;
    logic [11:0]  awid;
    logic [63:0]  awaddr;
    logic [9:0]   awlen;
    logic [2:0]   awsize;
    logic         awvalid, awready;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast, wvalid, wready;
    logic [11:0]  bid;
    logic [1:0]   bresp;
    logic         bvalid, bready;
    logic [11:0]  arid;
    logic [63:0]  araddr;
    logic [9:0]   arlen;
    logic [2:0]   arsize;
    logic         arvalid, arready;
    logic [11:0]  rid;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 axi4_mm_clk = ~axi4_mm_clk;

    cxl_mem_responder #(
        .MEM_DEPTH_LOG2(DEPTH_LOG2),
        .BASE_ADDR     (BASE),
        .RD_LATENCY    (RDL)
    ) dut (
        .axi4_mm_clk(axi4_mm_clk), .axi4_mm_rst(axi4_mm_rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic aw_send(input logic [63:0] addr, input logic [9:0] len, input logic [11:0] id);
        int n = 0;
        awaddr = addr; awlen = len; awid = id; awsize = 3'd6; awvalid = 1'b1;
        while (!awready && n < 50) begin @(negedge axi4_mm_clk); n++; end
        check_val("aw_ready", awready, 1);
        @(negedge axi4_mm_clk);
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [511:0] d, input logic [63:0] s, input logic l);
        int n = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        while (!wready && n < 50) begin @(negedge axi4_mm_clk); n++; end
        check_val("w_ready", wready, 1);
        @(negedge axi4_mm_clk);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_recv(input logic [11:0] id, input logic [1:0] resp);
        int n = 0;
        while (!bvalid && n < 50) begin @(negedge axi4_mm_clk); n++; end
        check_val("b_valid", bvalid, 1);
        check_val("b_id", bid, id);
        check_val("b_resp", bresp, resp);
        bready = 1'b1;
        @(negedge axi4_mm_clk);
        bready = 1'b0;
    endtask

    task automatic ar_send(input logic [63:0] addr, input logic [9:0] len, input logic [11:0] id);
        int n = 0;
        araddr = addr; arlen = len; arid = id; arsize = 3'd6; arvalid = 1'b1;
        while (!arready && n < 50) begin @(negedge axi4_mm_clk); n++; end
        check_val("ar_ready", arready, 1);
        @(negedge axi4_mm_clk);
        arvalid = 1'b0;
        n = 1;
        while (!rvalid && n < 20) begin @(negedge axi4_mm_clk); n++; end
        check_val("rd_latency", n, RDL);
    endtask

    task automatic r_recv(input logic [511:0] d, input logic [11:0] id, input logic l,
                          input logic [1:0] resp);
        int n = 0;
        while (!rvalid && n < 50) begin @(negedge axi4_mm_clk); n++; end
        check_val("r_valid", rvalid, 1);
        check_val("r_data", rdata, d);
        check_val("r_id", rid, id);
        check_val("r_last", rlast, l);
        check_val("r_resp", rresp, resp);
        rready = 1'b1;
        @(negedge axi4_mm_clk);
        rready = 1'b0;
    endtask

    logic [511:0] pat_a, exp_a, pd, w4, pe;
    logic [511:0] dq [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        axi4_mm_rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
        pat_a = {16{32'hCAFE_F00D}};
        for (int i = 0; i < 4; i++) dq[i] = {16{32'h1111_0000 + 32'(i)}};
        repeat (3) @(negedge axi4_mm_clk);

        check_val("rst_awready", awready, 0);
        check_val("rst_arready", arready, 0);
        check_val("rst_wready", wready, 0);
        check_val("rst_bvalid", bvalid, 0);
        check_val("rst_rvalid", rvalid, 0);
        check_val("rst_rdata", rdata, 0);
        axi4_mm_rst = 1'b0;
        @(negedge axi4_mm_clk);
        check_val("post_rst_awready", awready, 1);
        check_val("post_rst_arready", arready, 1);

        // single write then read
        aw_send(BASE + 64'h40, 10'd0, 12'h5);
        w_send(pat_a, '1, 1'b1);
        b_recv(12'h5, 2'b00);
        ar_send(BASE + 64'h40, 10'd0, 12'h9);
        r_recv(pat_a, 12'h9, 1'b1, 2'b00);

        // partial strobe
        pd = {16{32'h5555_AAAA}};
        pd[7:0] = 8'h7E;
        exp_a = pat_a;
        exp_a[7:0] = 8'h7E;
        aw_send(BASE + 64'h40, 10'd0, 12'h1);
        w_send(pd, 64'h1, 1'b1);
        b_recv(12'h1, 2'b00);
        ar_send(BASE + 64'h40, 10'd0, 12'h2);
        r_recv(exp_a, 12'h2, 1'b1, 2'b00);

        // wrapping burst from the last line, read back with rready toggling
        aw_send(BASE + 64'(255 * 64), 10'd3, 12'h3);
        for (int i = 0; i < 4; i++) w_send(dq[i], '1, i == 3);
        b_recv(12'h3, 2'b00);
        ar_send(BASE + 64'(255 * 64), 10'd3, 12'h4);
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 20 && !rvalid; n++) @(negedge axi4_mm_clk);
            check_val("burst_data", rdata, dq[i]);
            check_val("burst_last", rlast, i == 3);
            check_val("burst_id", rid, 12'h4);
            @(negedge axi4_mm_clk);
            check_val("stall_valid", rvalid, 1);
            check_val("stall_data", rdata, dq[i]);
            check_val("stall_last", rlast, i == 3);
            rready = 1'b1;
            @(negedge axi4_mm_clk);
            rready = 1'b0;
        end
        check_val("burst_done", rvalid, 0);
        ar_send(BASE, 10'd0, 12'h6);
        r_recv(dq[1], 12'h6, 1'b1, 2'b00);

        // wlast early and wlast missing
        w4 = {16{32'h7777_0001}};
        aw_send(BASE + 64'h80, 10'd2, 12'hA);
        w_send(w4, '1, 1'b1);
        b_recv(12'hA, 2'b10);
        ar_send(BASE + 64'h80, 10'd0, 12'hB);
        r_recv(w4, 12'hB, 1'b1, 2'b00);
        aw_send(BASE + 64'hC0, 10'd0, 12'hC);
        w_send(w4, '1, 1'b0);
        b_recv(12'hC, 2'b10);

        // reset during beat 1 of a 4-beat read
        pe = {16{32'hBEEF_0005}};
        aw_send(BASE + 64'h140, 10'd0, 12'hD);
        w_send(pe, '1, 1'b1);
        b_recv(12'hD, 2'b00);
        ar_send(BASE + 64'h140, 10'd3, 12'h7);
        r_recv(pe, 12'h7, 1'b0, 2'b00);
        for (int n = 0; n < 20 && !rvalid; n++) @(negedge axi4_mm_clk);
        axi4_mm_rst = 1'b1;
        #1;
        check_val("midrst_rvalid", rvalid, 0);
        check_val("midrst_rdata", rdata, 0);
        check_val("midrst_arready", arready, 0);
        @(negedge axi4_mm_clk);
        axi4_mm_rst = 1'b0;
        @(negedge axi4_mm_clk);
        check_val("midrst_arready_up", arready, 1);
        check_val("midrst_awready_up", awready, 1);
        ar_send(BASE + 64'h140, 10'd0, 12'h8);
        r_recv(pe, 12'h8, 1'b1, 2'b00);

`ifdef CXL_MEM_RANGE_CHECK_EN
        aw_send(BASE - 64'h40, 10'd0, 12'hE);
        w_send(pe, '1, 1'b1);
        b_recv(12'hE, 2'b11);
        ar_send(BASE - 64'h40, 10'd0, 12'hF);
        r_recv('0, 12'hF, 1'b1, 2'b11);
        ar_send(BASE + 64'(255 * 64), 10'd0, 12'h10);
        r_recv(dq[0], 12'h10, 1'b1, 2'b00);
`else
        // below BASE wraps onto the last line
        aw_send(BASE - 64'h40, 10'd0, 12'hE);
        w_send(pe, '1, 1'b1);
        b_recv(12'hE, 2'b00);
        ar_send(BASE + 64'(255 * 64), 10'd0, 12'h10);
        r_recv(pe, 12'h10, 1'b1, 2'b00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
